// File: rtl/fgba_pkg.sv
// Shared encodings for the memory-port arbiter slice.
package fgba_pkg;

  localparam logic [1:0] GRANT_NONE = 2'd0;
  localparam logic [1:0] GRANT_RPG  = 2'd1;
  localparam logic [1:0] GRANT_DMA  = 2'd2;
  localparam logic [1:0] GRANT_CPU  = 2'd3;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational winner selection: RPG first, then a forced CPU slot, then DMA, then CPU.
module arb_prio_pick
  import fgba_pkg::*;
(
  input  logic       rpg_req,
  input  logic       dma_req,
  input  logic       cpu_req,
  input  logic       cpu_force,
  output logic [1:0] pick_c
);

  // Fixed priority with the fairness override slotted between RPG and DMA
  always_comb begin
    pick_c = GRANT_NONE;
    if (rpg_req) begin
      pick_c = GRANT_RPG;
    end else if (cpu_req && cpu_force) begin
      pick_c = GRANT_CPU;
    end else if (dma_req) begin
      pick_c = GRANT_DMA;
    end else if (cpu_req) begin
      pick_c = GRANT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the RPG uploader, DMA and CPU with a CPU fairness slot
// and a watchdog that releases the port when memory never acknowledges.
module mem_arbiter
  import fgba_pkg::*;
#(
  parameter int unsigned CPU_SLOT = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] rpg_addr,
  input  logic [31:0] rpg_wdata,
  input  logic [1:0]  rpg_width,
  input  logic        rpg_read,
  input  logic        rpg_write,
  output logic [31:0] rpg_rdata,
  output logic        rpg_ok,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_width,
  input  logic        dma_read,
  input  logic        dma_write,
  output logic [31:0] dma_rdata,
  output logic        dma_ok,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ok,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_width,
  output logic        m_read,
  output logic        m_write,
  input  logic [31:0] m_rdata,
  input  logic        m_ok,
  output logic [1:0]  grant,
  output logic        timeout_flag
);

  localparam int unsigned RUN_W = $clog2(CPU_SLOT + 1);
  localparam int unsigned WD_W  = 8;

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [RUN_W-1:0]  dma_run;
  logic [WD_W-1:0]   wd_cnt;
  logic              rpg_req;
  logic              dma_req;
  logic              cpu_req;
  logic              cpu_force;
  logic [1:0]        pick_c;
  logic              done_c;
  logic              abort_c;
  logic [31:0]       done_data_c;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [1:0]        sel_width;
  logic              sel_read;
  logic              sel_write;
  logic [31:0]       rpg_rdata_q;
  logic [31:0]       dma_rdata_q;
  logic [31:0]       cpu_rdata_q;

  assign rpg_req   = rpg_read | rpg_write;
  assign dma_req   = dma_read | dma_write;
  assign cpu_req   = cpu_read | cpu_write;
  assign cpu_force = (dma_run == RUN_W'(CPU_SLOT));

  arb_prio_pick u_pick (
    .rpg_req   (rpg_req),
    .dma_req   (dma_req),
    .cpu_req   (cpu_req),
    .cpu_force (cpu_force),
    .pick_c    (pick_c)
  );

  // Route the winning requester's transaction fields toward the memory port
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_width = WIDTH_BYTE;
    sel_read  = 1'b0;
    sel_write = 1'b0;
    case (pick_c)
      GRANT_RPG: begin
        sel_addr = rpg_addr; sel_wdata = rpg_wdata; sel_width = rpg_width;
        sel_read = rpg_read; sel_write = rpg_write;
      end
      GRANT_DMA: begin
        sel_addr = dma_addr; sel_wdata = dma_wdata; sel_width = dma_width;
        sel_read = dma_read; sel_write = dma_write;
      end
      GRANT_CPU: begin
        sel_addr = cpu_addr; sel_wdata = cpu_wdata; sel_width = cpu_width;
        sel_read = cpu_read; sel_write = cpu_write;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state plus completion/abort detection; m_ok outside BUSY is ignored
  always_comb begin
    state_nxt = state;
    done_c    = 1'b0;
    abort_c   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_c != GRANT_NONE) state_nxt = BUSY;
      end
      BUSY: begin
        if (m_ok) begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end else if (wd_cnt == WD_W'(TIMEOUT)) begin
          done_c    = 1'b1;
          abort_c   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done_data_c = abort_c ? 32'd0 : m_rdata;

  // Completion pulse goes only to the granted requester; others show their held data
  assign rpg_ok    = done_c && (grant == GRANT_RPG);
  assign dma_ok    = done_c && (grant == GRANT_DMA);
  assign cpu_ok    = done_c && (grant == GRANT_CPU);
  assign rpg_rdata = rpg_ok ? done_data_c : rpg_rdata_q;
  assign dma_rdata = dma_ok ? done_data_c : dma_rdata_q;
  assign cpu_rdata = cpu_ok ? done_data_c : cpu_rdata_q;

  // Memory port, grant, watchdog, held read data and sticky abort flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_addr       <= '0;
      m_wdata      <= '0;
      m_width      <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      grant        <= GRANT_NONE;
      wd_cnt       <= '0;
      rpg_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (pick_c != GRANT_NONE) begin
            grant   <= pick_c;
            m_addr  <= sel_addr;
            m_wdata <= sel_wdata;
            m_width <= sel_width;
            m_read  <= sel_read & ~sel_write;
            m_write <= sel_write;
          end
        end
        BUSY: begin
          if (done_c) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
            grant   <= GRANT_NONE;
            case (grant)
              GRANT_RPG: rpg_rdata_q <= done_data_c;
              GRANT_DMA: dma_rdata_q <= done_data_c;
              GRANT_CPU: cpu_rdata_q <= done_data_c;
              default: ;
            endcase
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
          if (abort_c) timeout_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Count DMA completions while the CPU waits; any CPU completion or idle CPU clears it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dma_run <= '0;
    end else if (!cpu_req) begin
      dma_run <= '0;
    end else if (done_c && (grant == GRANT_CPU)) begin
      dma_run <= '0;
    end else if (done_c && (grant == GRANT_DMA) && !cpu_force) begin
      dma_run <= dma_run + RUN_W'(1);
    end
  end

endmodule
